// File: rtl/seq_pattern_pkg.sv
// Shared defaults and helpers for the sequence/pattern generator.
package seq_pattern_pkg;

    localparam int CNT_W_DEF   = 4;
    localparam int MODULUS_DEF = 10;
    localparam int NCH_DEF     = 1;

    // Count value from which the next enabled edge wraps, for a given direction.
    function automatic int term_val(input logic up, input int modulus);
        return up ? (modulus - 1) : 0;
    endfunction

endpackage

// File: rtl/seq_pattern_gen_mod_counter.sv
// Modulo-MODULUS up/down counter with clamped synchronous load and
// a combinational terminal-count flag.
module mod_counter
    import seq_pattern_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MODULUS = MODULUS_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MODULUS - 1);

    if (MODULUS < 2 || MODULUS > (1 << CNT_W)) begin : g_bad_modulus
        $error("mod_counter: MODULUS must lie in 2 .. 2**CNT_W");
    end

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: load (clamped to 0 when out of range) beats enable beats hold.
    always_comb begin
        count_d = count_q;
        if (load) begin
            if ({1'b0, load_val} < (CNT_W + 1)'(MODULUS))
                count_d = load_val;
            else
                count_d = '0;
        end else if (en) begin
            if (up)
                count_d = (count_q == MAX_V) ? '0 : count_q + CNT_W'(1);
            else
                count_d = (count_q == '0) ? MAX_V : count_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) count_q <= '0;
        else        count_q <= count_d;
    end

    // Terminal count flags the cycle whose edge will wrap; a load suppresses it.
    always_comb begin
        tc = en & ~load & (count_q == CNT_W'(term_val(up, MODULUS)));
    end

    assign count = count_q;

endmodule

// File: rtl/seq_pattern_gen.sv
// Programmable pattern generator: a modulo counter addresses a writable
// pattern memory whose addressed word is registered onto pat_out.
module seq_pattern_gen
    import seq_pattern_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MODULUS = MODULUS_DEF,
    parameter int NCH     = NCH_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_addr,
    input  logic [NCH-1:0]   wr_data,
    output logic [CNT_W-1:0] count,
    output logic             tc,
    output logic [NCH-1:0]   pat_out
);

    localparam int DEPTH = 1 << CNT_W;

    logic [NCH-1:0] mem_q [DEPTH];
    logic [NCH-1:0] mem_d [DEPTH];
    logic [NCH-1:0] pat_out_q, pat_out_d;

    mod_counter #(
        .CNT_W   (CNT_W),
        .MODULUS (MODULUS)
    ) u_cnt (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc)
    );

    // Write port: every address is writable, even those the counter never reaches.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_addr] = wr_data;
    end

    // Read from the pre-write contents so a same-cycle write to the counted
    // address shows up only on the next visit.
    always_comb begin
        pat_out_d = mem_q[count];
    end

    // Memory and output register; reset clears the whole pattern store.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            pat_out_q <= '0;
        end else begin
            mem_q     <= mem_d;
            pat_out_q <= pat_out_d;
        end
    end

    assign pat_out = pat_out_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: a default (M=10, 1 channel) and a 4-channel
// M=16 instance share control inputs and are checked against a reference.
module tb_seq_pattern_gen;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       en, up, load, wr_en;
    logic [3:0] load_val, wr_addr;
    logic       wr_da;
    logic [3:0] wr_db;
    logic [3:0] count_a, count_b;
    logic       tc_a, tc_b;
    logic       pat_a;
    logic [3:0] pat_b;

    int tests = 0;
    int fails = 0;

    // reference state
    int mc_a, mc_b;
    int mem_a [16];
    int mem_b [16];

    always #5 CLK = ~CLK;

    seq_pattern_gen dut_a (
        .CLK(CLK), .RST_N(RST_N), .en(en), .up(up), .load(load), .load_val(load_val),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_da),
        .count(count_a), .tc(tc_a), .pat_out(pat_a)
    );

    seq_pattern_gen #(.CNT_W(4), .MODULUS(16), .NCH(4)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .en(en), .up(up), .load(load), .load_val(load_val),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_db),
        .count(count_b), .tc(tc_b), .pat_out(pat_b)
    );

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic int ref_next(input int c, input int m);
        if (load)    return (int'(load_val) < m) ? int'(load_val) : 0;
        else if (en) return up ? (c + 1) % m : (c + m - 1) % m;
        else         return c;
    endfunction

    function automatic int ref_tc(input int c, input int m);
        return (en && !load && c == (up ? m - 1 : 0)) ? 1 : 0;
    endfunction

    task automatic ref_reset();
        mc_a = 0; mc_b = 0;
        for (int i = 0; i < 16; i++) begin mem_a[i] = 0; mem_b[i] = 0; end
    endtask

    // One clock cycle with the currently driven inputs, checked against the reference.
    int pa_m, pb_m;
    task automatic cyc();
        #1;
        chk("tc_a", tc_a, ref_tc(mc_a, 10));
        chk("tc_b", tc_b, ref_tc(mc_b, 16));
        pa_m = mem_a[mc_a];
        pb_m = mem_b[mc_b];
        if (wr_en) begin
            mem_a[wr_addr] = wr_da;
            mem_b[wr_addr] = wr_db;
        end
        mc_a = ref_next(mc_a, 10);
        mc_b = ref_next(mc_b, 16);
        @(posedge CLK);
        #1;
        chk("count_a", count_a, mc_a);
        chk("pat_a",   pat_a,   pa_m);
        chk("count_b", count_b, mc_b);
        chk("pat_b",   pat_b,   pb_m);
    endtask

    task automatic drive(input logic e, input logic u, input logic l, input int lv,
                         input logic we, input int wa, input int wd);
        en = e; up = u; load = l; load_val = 4'(lv);
        wr_en = we; wr_addr = 4'(wa); wr_da = wd[0]; wr_db = 4'(wd);
    endtask

    typedef struct {
        logic en, up, wr_en;
        int   wr_addr, wr_d;
        int   exp_tc, exp_cnt, exp_pat;
    } vec_t;
    vec_t tbl [18];

    int dn_exp [5] = '{2, 1, 0, 9, 8};
    int dn_tc  [5] = '{0, 0, 0, 1, 0};
    int prev;

    initial begin
        // Program mem[0..5]=1 with the counter idle, then count up 12 edges.
        for (int i = 0; i < 6; i++)
            tbl[i] = '{1'b0, 1'b1, 1'b1, i, 1, 0, 0, (i == 0) ? 0 : 1};
        for (int k = 0; k < 12; k++)
            tbl[6 + k] = '{1'b1, 1'b1, 1'b0, 0, 0, (k == 9) ? 1 : 0,
                           (k + 1) % 10, ((k % 10) < 6) ? 1 : 0};

        RST_N = 1'b0;
        drive(0, 1, 0, 0, 0, 0, 0);
        ref_reset();
        #2;
        chk("rst_count", count_a, 0);
        chk("rst_pat",   pat_a,   0);
        chk("rst_tc",    tc_a,    0);
        chk("rst_pat_b", pat_b,   0);
        #6 RST_N = 1'b1;

        // Table: programming then up-count wrap
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].en, tbl[i].up, 0, 0, tbl[i].wr_en, tbl[i].wr_addr, tbl[i].wr_d);
            #1;
            chk("tbl_tc", tc_a, tbl[i].exp_tc);
            cyc();
            chk("tbl_count", count_a, tbl[i].exp_cnt);
            chk("tbl_pat",   pat_a,   tbl[i].exp_pat);
        end

        // Down count from 3 with wrap, then flip direction at 8
        drive(1, 0, 1, 3, 0, 0, 0);
        cyc();
        chk("dn_load", count_a, 3);
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            #1;
            chk("dn_tc", tc_a, dn_tc[k]);
            cyc();
            chk("dn_count", count_a, dn_exp[k]);
        end
        drive(1, 1, 0, 0, 0, 0, 0);
        cyc();
        chk("flip_count", count_a, 9);

        // Load priority and clamping
        drive(1, 1, 1, 12, 0, 0, 0);
        #1;
        chk("clamp_tc", tc_a, 0);
        cyc();
        chk("clamp_count",   count_a, 0);
        chk("noclamp_cnt_b", count_b, 12);
        drive(1, 1, 1, 6, 0, 0, 0);
        cyc();
        chk("load6_count", count_a, 6);

        // Read/write collision at address 4
        drive(0, 1, 1, 4, 1, 4, 0);
        cyc();
        drive(0, 1, 0, 0, 1, 4, 1);
        cyc();
        chk("coll_old", pat_a, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        cyc();
        chk("coll_new", pat_a, 1);

        // Multi-channel: mem_b[i]=i, count from 0 across the 15->0 wrap
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0, 0, 1, i, i);
            cyc();
        end
        drive(0, 1, 1, 0, 0, 0, 0);
        cyc();
        for (int k = 0; k < 18; k++) begin
            drive(1, 1, 0, 0, 0, 0, 0);
            #1;
            chk("mc_tc", tc_b, (k % 16 == 15) ? 1 : 0);
            prev = k % 16;
            cyc();
            chk("mc_pat",   pat_b,   prev);
            chk("mc_count", count_b, (prev + 1) % 16);
        end

        // Randomised traffic
        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 15),
                  1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15));
            cyc();
        end

        // Asynchronous reset mid-run with count=7
        drive(0, 1, 1, 7, 0, 0, 0);
        cyc();
        chk("pre_rst_count", count_a, 7);
        drive(0, 1, 0, 0, 0, 0, 0);
        RST_N = 1'b0;
        #1;
        ref_reset();
        chk("arst_count", count_a, 0);
        chk("arst_pat",   pat_a,   0);
        chk("arst_pat_b", pat_b,   0);
        #2 RST_N = 1'b1;
        for (int k = 0; k < 16; k++) begin
            drive(1, 1, 0, 0, 0, 0, 0);
            cyc();
            chk("post_rst_pat_a", pat_a, 0);
            chk("post_rst_pat_b", pat_b, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
